// File: rtl/cc_cond_unit_if.sv
// Execute-to-memory condition-code bus: ALU operands/result and control in, CC and cnd out.
interface cc_cond_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;
    logic             set_cc;
    logic [3:0]       ifun;
    logic             stall;
    logic             flush;
    logic             exc_inhibit;
    logic [2:0]       cc_q;
    logic             out_valid;
    logic             cnd_q;
    logic             bad_ifun;

    modport master (
        output in_valid, op, a, b, alu_res, set_cc, ifun, stall, flush, exc_inhibit,
        input  cc_q, out_valid, cnd_q, bad_ifun
    );

    modport slave (
        input  in_valid, op, a, b, alu_res, set_cc, ifun, stall, flush, exc_inhibit,
        output cc_q, out_valid, cnd_q, bad_ifun
    );
endinterface

// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator with a registered output stage.
// Optional macro CC_BYPASS_EN: evaluate cnd against freshly derived flags on a same-cycle CC update.
module cc_cond_unit #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input logic         clk,
    input logic         rst_n,
    cc_cond_unit_if.slave bus
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    logic [2:0] r_cc;
    logic       r_out_valid;
    logic       r_cnd;
    logic       r_bad_ifun;

    logic       w_zf;
    logic       w_sf;
    logic       w_of;
    logic       w_a_msb;
    logic       w_b_msb;
    logic       w_res_msb;
    logic       w_acc;
    logic       w_cc_upd;
    logic [2:0] w_cc_new;
    logic [2:0] w_cc_eval;
    logic       w_cnd;
    logic       w_bad;

    // Flags come from operand/result sign bits only; carry-out never feeds OF.
    assign w_a_msb   = bus.a[WIDTH-1];
    assign w_b_msb   = bus.b[WIDTH-1];
    assign w_res_msb = bus.alu_res[WIDTH-1];
    assign w_zf      = (bus.alu_res == '0);
    assign w_sf      = w_res_msb;

    always_comb begin
        w_of = 1'b0;
        case (bus.op)
            OP_ADD:  w_of = (w_a_msb == w_b_msb) && (w_res_msb != w_a_msb);
            OP_SUB:  w_of = (w_a_msb != w_b_msb) && (w_res_msb != w_a_msb);
            default: w_of = 1'b0;
        endcase
    end

    assign w_cc_new = {w_zf, w_sf, w_of};
    assign w_acc    = bus.in_valid && !bus.stall && !bus.flush;
    assign w_cc_upd = w_acc && bus.set_cc && !bus.exc_inhibit;

`ifdef CC_BYPASS_EN
    assign w_cc_eval = w_cc_upd ? w_cc_new : r_cc;
`else
    assign w_cc_eval = r_cc;
`endif

    // Condition function over {Z,S,O}; codes above 6 are undefined and evaluate false.
    always_comb begin
        logic w_z;
        logic w_s;
        logic w_o;
        w_z   = w_cc_eval[2];
        w_s   = w_cc_eval[1];
        w_o   = w_cc_eval[0];
        w_cnd = 1'b0;
        case (bus.ifun)
            4'd0:    w_cnd = 1'b1;
            4'd1:    w_cnd = (w_s ^ w_o) | w_z;
            4'd2:    w_cnd = w_s ^ w_o;
            4'd3:    w_cnd = w_z;
            4'd4:    w_cnd = !w_z;
            4'd5:    w_cnd = !(w_s ^ w_o);
            4'd6:    w_cnd = !(w_s ^ w_o) && !w_z;
            default: w_cnd = 1'b0;
        endcase
    end

    assign w_bad = bus.in_valid && (bus.ifun > 4'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_cc_upd) begin
            r_cc <= w_cc_new;
        end
    end

    // Flush squashes validity but keeps the last cnd/bad values; stall freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_cnd       <= 1'b0;
            r_bad_ifun  <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_out_valid <= bus.in_valid;
            r_cnd       <= w_cnd;
            r_bad_ifun  <= w_bad;
        end
    end

    assign bus.cc_q      = r_cc;
    assign bus.out_valid = r_out_valid;
    assign bus.cnd_q     = r_cnd;
    assign bus.bad_ifun  = r_bad_ifun;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed vector table plus randomized run against an arithmetic reference model of cc_cond_unit.
module tb_cc_cond_unit;
    localparam int W = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cc_cond_unit_if #(.WIDTH(W)) bus ();

    cc_cond_unit #(.WIDTH(W), .CC_RESET(3'b100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         set;
        logic [3:0]   ifun;
        logic         st;
        logic         fl;
        logic         exc;
        logic [2:0]   e_cc;
        logic         e_ov;
        logic         e_cnd;
        logic         e_bad;
    } vec_t;

    vec_t vecs[16];

    // Reference model state
    logic [2:0] m_cc;
    logic       m_ov;
    logic       m_cnd;
    logic       m_bad;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] cc, input logic ov,
                             input logic cnd, input logic bad);
        chk({tag, ".cc_q"}, bus.cc_q, cc);
        chk({tag, ".out_valid"}, {2'b0, bus.out_valid}, {2'b0, ov});
        chk({tag, ".cnd_q"}, {2'b0, bus.cnd_q}, {2'b0, cnd});
        chk({tag, ".bad_ifun"}, {2'b0, bus.bad_ifun}, {2'b0, bad});
    endtask

    task automatic drive(input vec_t t);
        bus.in_valid    = t.v;
        bus.op          = t.op;
        bus.a           = t.a;
        bus.b           = t.b;
        bus.alu_res     = t.res;
        bus.set_cc      = t.set;
        bus.ifun        = t.ifun;
        bus.stall       = t.st;
        bus.flush       = t.fl;
        bus.exc_inhibit = t.exc;
    endtask

    function automatic logic eval_cond(input logic [3:0] f, input logic [2:0] cc);
        logic z, s, o;
        z = cc[2]; s = cc[1]; o = cc[0];
        case (f)
            4'd0: return 1'b1;
            4'd1: return (s != o) || z;
            4'd2: return s != o;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return s == o;
            4'd6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Flags from true signed arithmetic: OF means the exact result does not fit in W bits.
    function automatic logic [2:0] flags_of(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] res);
        logic signed [W:0] exact;
        logic              of;
        of = 1'b0;
        if (op == 2'b00) begin
            exact = $signed({a[W-1], a}) + $signed({b[W-1], b});
            of = (exact > $signed({2'b00, {(W-1){1'b1}}})) ||
                 (exact < $signed({2'b11, {(W-1){1'b0}}}));
        end else if (op == 2'b01) begin
            exact = $signed({a[W-1], a}) - $signed({b[W-1], b});
            of = (exact > $signed({2'b00, {(W-1){1'b1}}})) ||
                 (exact < $signed({2'b11, {(W-1){1'b0}}}));
        end
        return {res == '0, res[W-1], of};
    endfunction

    function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] x;
        case ($urandom_range(0, 5))
            0: x = '0;
            1: x = {1'b0, {(W-1){1'b1}}};
            2: x = {1'b1, {(W-1){1'b0}}};
            3: x = {W{1'b1}};
            4: x = W'($urandom_range(0, 7));
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    task automatic model_step(input vec_t t);
        logic       upd;
        logic [2:0] nf;
        logic [2:0] ev;
        upd = t.v && !t.st && !t.fl && t.set && !t.exc;
        nf  = flags_of(t.op, t.a, t.b, t.res);
        ev  = m_cc;
`ifdef CC_BYPASS_EN
        if (upd) ev = nf;
`endif
        if (t.fl) begin
            m_ov = 1'b0;
        end else if (!t.st) begin
            m_ov  = t.v;
            m_cnd = eval_cond(t.ifun, ev);
            m_bad = t.v && (t.ifun > 4'd6);
        end
        if (upd) m_cc = nf;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res,
                                input logic set, input logic [3:0] ifun, input logic st,
                                input logic fl, input logic exc, input logic [2:0] e_cc,
                                input logic e_ov, input logic e_cnd, input logic e_bad);
        vec_t t;
        t.v = v; t.op = op; t.a = a; t.b = b; t.res = res; t.set = set; t.ifun = ifun;
        t.st = st; t.fl = fl; t.exc = exc;
        t.e_cc = e_cc; t.e_ov = e_ov; t.e_cnd = e_cnd; t.e_bad = e_bad;
        return t;
    endfunction

    initial begin
        logic [W-1:0] max_pos;
        logic [W-1:0] min_neg;
        logic         byp_cnd;
        vec_t         t;
        n_checks = 0;
        n_errors = 0;
        max_pos  = {1'b0, {(W-1){1'b1}}};
        min_neg  = {1'b1, {(W-1){1'b0}}};
`ifdef CC_BYPASS_EN
        byp_cnd = 1'b1;
`else
        byp_cnd = 1'b0;
`endif
        //            v  op     a        b     res      set ifun  st fl exc  cc     ov cnd bad
        vecs[0]  = mk(1, 2'b00, max_pos, 64'd1, min_neg, 1, 4'd0, 0, 0, 0, 3'b011, 1, 1, 0);
        vecs[1]  = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd2, 0, 0, 0, 3'b011, 1, 0, 0);
        vecs[2]  = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd5, 0, 0, 0, 3'b011, 1, 1, 0);
        vecs[3]  = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd1, 0, 0, 0, 3'b011, 1, 0, 0);
        vecs[4]  = mk(1, 2'b01, 64'd5,   64'd5, 64'd0,   1, 4'd0, 0, 0, 0, 3'b100, 1, 1, 0);
        vecs[5]  = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd3, 0, 0, 0, 3'b100, 1, 1, 0);
        vecs[6]  = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd6, 0, 0, 0, 3'b100, 1, 0, 0);
        vecs[7]  = mk(1, 2'b00, 64'd1,   64'd1, 64'd2,   1, 4'd3, 1, 0, 0, 3'b100, 1, 0, 0);
        vecs[8]  = mk(1, 2'b00, 64'd1,   64'd1, 64'd2,   1, 4'd3, 1, 0, 0, 3'b100, 1, 0, 0);
        vecs[9]  = mk(1, 2'b00, 64'd1,   64'd1, 64'd2,   1, 4'd3, 1, 1, 0, 3'b100, 0, 0, 0);
        vecs[10] = mk(1, 2'b00, 64'd1,   64'd1, 64'd2,   1, 4'd3, 0, 0, 1, 3'b100, 1, 1, 0);
        vecs[11] = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'hA, 0, 0, 0, 3'b100, 1, 0, 1);
        vecs[12] = mk(1, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'd0, 0, 0, 0, 3'b100, 1, 1, 0);
        vecs[13] = mk(0, 2'b10, 64'd0,   64'd0, 64'd0,   0, 4'hF, 0, 0, 0, 3'b100, 0, 0, 0);
        vecs[14] = mk(1, 2'b00, 64'd1,   64'd1, 64'd2,   1, 4'd0, 0, 0, 0, 3'b000, 1, 1, 0);
        vecs[15] = mk(1, 2'b01, 64'd3,   64'd3, 64'd0,   1, 4'd3, 0, 0, 0, 3'b100, 1, byp_cnd, 0);

        // Power-on reset
        t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        rst_n = 1'b0;
        #12;
        check_all("reset", 3'b100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            $display("vec %0d: ifun=%0h st=%0b fl=%0b exc=%0b -> cc=%b ov=%b cnd=%b bad=%b",
                     i, vecs[i].ifun, vecs[i].st, vecs[i].fl, vecs[i].exc,
                     bus.cc_q, bus.out_valid, bus.cnd_q, bus.bad_ifun);
            check_all($sformatf("vec%0d", i), vecs[i].e_cc, vecs[i].e_ov,
                      vecs[i].e_cnd, vecs[i].e_bad);
        end

        // Bring state away from reset values, then assert reset mid-cycle while stalled
        @(negedge clk);
        drive(mk(1, 2'b00, max_pos, 64'd1, min_neg, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_all("pre_reset", 3'b011, 1'b1, 1'b1, 1'b0);
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle: cc=%b ov=%b cnd=%b", bus.cc_q, bus.out_valid, bus.cnd_q);
        check_all("async_reset", 3'b100, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_hold", 3'b100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the reference model
        m_cc = 3'b100; m_ov = 1'b0; m_cnd = 1'b0; m_bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            t.v   = ($urandom_range(0, 7) != 0);
            t.op  = 2'($urandom_range(0, 3));
            t.a   = rnd_operand();
            t.b   = rnd_operand();
            t.res = alu(t.op, t.a, t.b);
            t.set = ($urandom_range(0, 2) != 0);
            t.ifun = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15))
                                                 : 4'($urandom_range(0, 6));
            t.st  = ($urandom_range(0, 7) == 0);
            t.fl  = ($urandom_range(0, 9) == 0);
            t.exc = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            drive(t);
            model_step(t);
            @(posedge clk);
            #1;
            $display("rnd %0d: v=%0b op=%0d set=%0b ifun=%0h st=%0b fl=%0b exc=%0b -> cc=%b ov=%b cnd=%b bad=%b",
                     i, t.v, t.op, t.set, t.ifun, t.st, t.fl, t.exc,
                     bus.cc_q, bus.out_valid, bus.cnd_q, bus.bad_ifun);
            check_all($sformatf("rnd%0d", i), m_cc, m_ov, m_cnd, m_bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
